pipe_stage_chain: RTL
=====================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter W_DATA, default 32, giving the data word width in bits (legal range 1..1024).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (legal range 1..16).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: upstream word present.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 The block SHALL have port i_data, input, W_DATA bits: the upstream word.
REQ-008 The block SHALL have port o_valid, output, 1 bit: the last stage holds a word.
REQ-009 The block SHALL have port i_ready, input, 1 bit: downstream accepts this cycle.
REQ-010 The block SHALL have port o_data, output, W_DATA bits: the last-stage word.
REQ-011 The block SHALL have port i_flush, input, 1 bit: synchronous discard of all held words.
REQ-012 The block SHALL have port o_occ, output, 5 bits, present only under PIPE_OCC_COUNT_EN: the number of occupied stages.

Function
REQ-013 An input transfer SHALL occur on any edge where i_valid and o_ready are both 1; an output transfer SHALL occur where o_valid and i_ready are both 1.
REQ-014 Stage k (0..DEPTH-1, stage 0 at the input) SHALL hold one valid bit and one W_DATA word.
REQ-015 Stage k SHALL advance when it is empty or when stage k+1 advances; the last stage advances when it is empty or i_ready is 1.
REQ-016 o_ready SHALL equal (stage 0 advance) AND NOT i_flush, computed combinationally.
REQ-017 On advance, stage k SHALL load the valid bit and data of stage k-1; stage 0 loads i_valid and i_data.
REQ-018 A stage whose valid bit is 0 SHALL collapse, so bubbles are squeezed out.
REQ-019 With i_ready held at 1, a word accepted at edge n SHALL appear on o_valid/o_data after edge n+DEPTH-1 and remain in the last stage until it is taken.
REQ-020 Sustained throughput SHALL be one word per cycle when i_valid and i_ready are both held at 1.
REQ-021 The block SHALL hold at most DEPTH words; when all stages are valid and i_ready is 0, o_ready SHALL be 0.
REQ-022 When the block is full and i_ready is 1, o_ready SHALL be 1 in the same cycle, and simultaneous input and output transfers SHALL occur.
REQ-023 o_data SHALL be held stable while o_valid is 1 and i_ready is 0.
REQ-024 While i_flush is 1, the next edge SHALL clear every valid bit and o_ready SHALL be 0.
REQ-025 An output transfer coinciding with i_flush SHALL still complete; the word counts as delivered.
REQ-026 Data registers SHALL be enabled only on advance; they need not be cleared.

Reset
REQ-027 While i_rst is 1, all valid bits SHALL be 0, o_valid 0, and o_occ 0, immediately and without waiting for a clock edge.
REQ-028 While i_rst is 1, o_ready SHALL be 0.
REQ-029 Reset asserted mid-stream SHALL discard all held words; after release, operation SHALL restart empty on the first edge.

Configuration
REQ-030 With PIPE_OCC_COUNT_EN defined, o_occ SHALL be a registered count.
REQ-031 Under PIPE_OCC_COUNT_EN, o_occ SHALL increment on an input-only transfer, decrement on an output-only transfer, stay unchanged on both, and go to 0 on flush.
REQ-032 Under PIPE_OCC_COUNT_EN, the count SHALL never exceed DEPTH.
REQ-033 Without PIPE_OCC_COUNT_EN, port o_occ and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Latency (DEPTH=4, W_DATA=32): i_ready=1; send 0xA5A5_0001 at edge 0 -> o_valid=1, o_data=0xA5A5_0001 after edge 3.
REQ-035 Streaming: send 0x0..0x63 back-to-back with i_ready=1 -> 100 words out in order, one per cycle, and o_ready never 0.
REQ-036 Backpressure and full: i_ready=0; offer 6 words -> 4 accepted, o_ready=0, o_occ=4.
REQ-037 Full pass-through: from the REQ-036 state, raise i_ready -> an input and an output transfer occur on the same edge, and o_occ stays 4.
REQ-038 Flush: with 3 words held, pulse i_flush for 1 cycle -> o_valid=0 next cycle, o_occ=0, and the word offered during the flush is not accepted.
REQ-039 Reset: assert i_rst mid-stream with 2 words held -> o_valid=0 without a clock edge; after release, a new word 0x1234 emerges after the REQ-019 latency.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with ready/valid handshakes, bubble collapse and flush.
// Optional occupancy counter port o_occ is enabled by defining PIPE_OCC_COUNT_EN.
module pipe_stage_chain #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data,
`ifdef PIPE_OCC_COUNT_EN
  output logic [4:0]        o_occ,
`endif
  input  logic              i_flush
);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;
  logic [DEPTH-1:0]  adv;
  logic [W_DATA-1:0] data_q [DEPTH];

  // A stage may move when any stage at or beyond it is empty, or the sink takes the last word.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = i_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!vld_q[j]) adv[k] = 1'b1;
      end
    end
  end

  assign o_ready = adv[0] & ~i_flush & ~i_rst;
  assign o_valid = vld_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

  always_comb begin
    vld_d = vld_q;
    if (adv[0]) vld_d[0] = i_valid;
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) vld_d[k] = vld_q[k-1];
    end
    if (i_flush) vld_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  // Data words carry no reset; their validity is tracked entirely by vld_q.
  always_ff @(posedge i_clk) begin
    if (adv[0]) data_q[0] <= i_data;
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) data_q[k] <= data_q[k-1];
    end
  end

`ifdef PIPE_OCC_COUNT_EN
  logic       in_xfer;
  logic       out_xfer;
  logic [4:0] occ_q;
  logic [4:0] occ_d;

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  always_comb begin
    occ_d = occ_q;
    if (i_flush)                    occ_d = 5'd0;
    else if (in_xfer && !out_xfer && occ_q < 5'(DEPTH)) occ_d = occ_q + 5'd1;
    else if (out_xfer && !in_xfer && occ_q != 5'd0)     occ_d = occ_q - 5'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) occ_q <= 5'd0;
    else       occ_q <= occ_d;
  end

  assign o_occ = occ_q;
`endif

endmodule
